// File: rtl/cpu32_pkg.sv
// Shared types and constants for the 32-bit fetch front end.
package cpu32_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam int unsigned FETCH_CNT_W = 2;
    localparam int unsigned FETCH_PTR_W = 1;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between the fetch port and the decoder.
module fetch_buffer
    import cpu32_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [FETCH_CNT_W-1:0] count,
    output fetch_entry_t           head
);

    fetch_entry_t           mem_q [FETCH_DEPTH];
    logic [FETCH_PTR_W-1:0] wr_ptr_q;
    logic [FETCH_PTR_W-1:0] rd_ptr_q;
    logic [FETCH_CNT_W-1:0] count_q;
    logic                   do_push;
    logic                   do_pop;

    // Flush wins over everything; a push into a full buffer is only taken alongside a pop.
    always_comb begin
        do_pop  = pop && !flush && (count_q != '0);
        do_push = push && !flush &&
                  ((count_q != FETCH_CNT_W'(FETCH_DEPTH)) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + FETCH_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FETCH_PTR_W'(1);
            end
            count_q <= count_q + FETCH_CNT_W'(do_push) - FETCH_CNT_W'(do_pop);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, two-entry buffer, redirect/squash.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirect raises a sticky
// fault that blocks fetching; without it the redirect target is word-aligned and fault is 0.
module fetch_unit
    import cpu32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fault
);

    fetch_state_e           state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic                   squash_q, squash_d;
    logic                   fault_q, fault_d;
    logic [XLEN-1:0]        target;
    logic                   bad_target;
    logic                   ack_seen;
    logic                   buf_push, buf_pop, buf_flush;
    logic [FETCH_CNT_W-1:0] buf_count;
    logic [FETCH_CNT_W-1:0] count_after;
    fetch_entry_t           buf_head;
    fetch_entry_t           push_entry;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign bad_target = (redirect_pc[1:0] != 2'b00);
    assign fault      = fault_q;
`else
    assign target     = redirect_pc & ~XLEN'(3);
    assign bad_target = 1'b0;
    assign fault      = 1'b0;
`endif

    // State register for FSM, PC, request address and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            squash_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            squash_q <= squash_d;
            fault_q  <= fault_d;
        end
    end

    // Next state: redirect first, then ack/push, then issue. A request that completes
    // this cycle frees the port, so the next one is issued on the same edge.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        squash_d    = squash_q;
        fault_d     = fault_q;
        buf_push    = 1'b0;
        buf_pop     = 1'b0;
        buf_flush   = 1'b0;
        ack_seen    = (state_q == ST_WAIT) && imem_ack;
        count_after = buf_count;

        if (redirect_valid) begin
            buf_flush = 1'b1;
            fault_d   = bad_target;
            pc_d      = target;
            squash_d  = (state_q == ST_WAIT) && !imem_ack;
            if ((state_q == ST_WAIT) && !imem_ack) begin
                state_d = ST_WAIT;
            end else if (!bad_target) begin
                state_d = ST_WAIT;
                addr_d  = target;
                pc_d    = target + INST_BYTES;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            buf_pop = inst_valid && inst_ready;
            if (ack_seen) begin
                buf_push = !squash_q;
                squash_d = 1'b0;
                state_d  = ST_IDLE;
            end
            count_after = buf_count + FETCH_CNT_W'(buf_push) - FETCH_CNT_W'(buf_pop);
            if (((state_q == ST_IDLE) || ack_seen) && !fault_q &&
                (count_after < FETCH_CNT_W'(FETCH_DEPTH))) begin
                state_d = ST_WAIT;
                addr_d  = pc_q;
                pc_d    = pc_q + INST_BYTES;
            end
        end
    end

    assign push_entry = {addr_q, imem_rdata};

    fetch_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (push_entry),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign imem_req   = (state_q == ST_WAIT);
    assign imem_addr  = addr_q;
    assign inst_valid = (buf_count != '0);
    assign inst       = buf_head.inst;
    assign inst_pc    = buf_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model, decoder monitor, directed scenarios.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [63:0] exp_q[$];

    // memory model controls
    int          lat       = 1;
    int          cnt       = 0;
    bit          hold_on   = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    bit          stray_ack = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back({pc, word});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (pops < target) begin
            errors++;
            $display("FAIL %s: got %0d transfers expected %0d within %0d cycles", name, pops, target, budget);
        end
    endtask

    task automatic wait_req(input logic [31:0] addr, input int budget, input string name);
        int n;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === addr) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (!(imem_req === 1'b1 && imem_addr === addr)) begin
            errors++;
            $display("FAIL %s: got req %b addr %h expected req 1 addr %h", name, imem_req, imem_addr, addr);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        pops = 0;
        step(3);
        rst_n = 1'b1;
    endtask

    // Memory: ack 'lat' cycles after a request appears; hold_addr is never acked while hold_on.
    initial forever begin
        @(negedge clk);
        if (stray_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
        end else if (imem_req !== 1'b1 || imem_ack) begin
            imem_ack = 1'b0;
            cnt      = (imem_req === 1'b1) ? 1 : 0;
        end else if (cnt >= lat && !(hold_on && imem_addr == hold_addr)) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr + 32'hA000_0000;
        end else begin
            cnt++;
        end
    end

    // Decoder-side monitor: every accepted instruction is checked against the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
                end else begin
                    e = exp_q.pop_front();
                    check32("inst_pc", inst_pc, e[63:32]);
                    check32("inst", inst, e[31:0]);
                end
                pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step(2);

        // reset values
        check1("rst_imem_req", imem_req, 1'b0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check32("rst_inst", inst, 32'h0);
        check32("rst_inst_pc", inst_pc, 32'h0);
        check1("rst_fault", fault, 1'b0);

        // streaming, 1-cycle memory, decoder always ready
        inst_ready = 1'b1;
        expect_inst(32'h0000_0000, 32'hA000_0000);
        expect_inst(32'h0000_0004, 32'hA000_0004);
        expect_inst(32'h0000_0008, 32'hA000_0008);
        expect_inst(32'h0000_000C, 32'hA000_000C);
        expect_inst(32'h0000_0010, 32'hA000_0010);
        rst_n = 1'b1;
        step(1);
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, 32'h0000_0000);
        wait_pops(3, 8, "stream_three");

        // decoder stalled: two entries buffered, fetch stops, head stable
        inst_ready = 1'b0;
        do_reset();
        expect_inst(32'h0000_0000, 32'hA000_0000);
        expect_inst(32'h0000_0004, 32'hA000_0004);
        expect_inst(32'h0000_0008, 32'hA000_0008);
        expect_inst(32'h0000_000C, 32'hA000_000C);
        step(5);
        check32("stall_head_mid", inst_pc, 32'h0000_0000);
        step(5);
        check1("stall_no_req", imem_req, 1'b0);
        check1("stall_valid", inst_valid, 1'b1);
        check32("stall_head_pc", inst_pc, 32'h0000_0000);
        check32("stall_head_inst", inst, 32'hA000_0000);
        inst_ready = 1'b1;
        step(1);
        check1("stall_second_valid", inst_valid, 1'b1);
        check32("stall_second_pc", inst_pc, 32'h0000_0004);
        step(1);
        check1("stall_only_two", inst_valid, 1'b0);
        check32("stall_next_addr", imem_addr, 32'h0000_0008);
        wait_pops(3, 6, "stall_third");

        // redirect while waiting on 0x8, ack arrives 3 cycles later and is dropped
        inst_ready = 1'b1;
        hold_on    = 1'b1;
        hold_addr  = 32'h0000_0008;
        do_reset();
        expect_inst(32'h0000_0000, 32'hA000_0000);
        expect_inst(32'h0000_0004, 32'hA000_0004);
        wait_req(32'h0000_0008, 10, "wait_on_8");
        step(2);
        check32("drain_before_redirect", 32'(pops), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        exp_q.delete();
        expect_inst(32'h0000_0100, 32'hA000_0100);
        expect_inst(32'h0000_0104, 32'hA000_0104);
        step(1);
        redirect_valid = 1'b0;
        check1("squash_valid", inst_valid, 1'b0);
        check1("squash_req_held", imem_req, 1'b1);
        check32("squash_addr_held", imem_addr, 32'h0000_0008);
        step(2);
        hold_on = 1'b0;
        step(1);
        check1("after_squash_req", imem_req, 1'b1);
        check32("after_squash_addr", imem_addr, 32'h0000_0100);
        wait_pops(4, 10, "after_squash");

        // redirect in the same cycle as ack and pop
        inst_ready = 1'b0;
        hold_on    = 1'b1;
        hold_addr  = 32'h0000_0004;
        do_reset();
        step(4);
        check1("pre_same_valid", inst_valid, 1'b1);
        check32("pre_same_addr", imem_addr, 32'h0000_0004);
        hold_on        = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        exp_q.delete();
        expect_inst(32'h0000_0200, 32'hA000_0200);
        expect_inst(32'h0000_0204, 32'hA000_0204);
        step(1);
        redirect_valid = 1'b0;
        check1("same_flushed", inst_valid, 1'b0);
        check1("same_req", imem_req, 1'b1);
        check32("same_addr", imem_addr, 32'h0000_0200);
        wait_pops(1, 8, "same_first");

        // misaligned redirect
        inst_ready = 1'b0;
        do_reset();
        step(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
`ifdef FETCH_ALIGN_CHECK_EN
        step(1);
        redirect_valid = 1'b0;
        check1("mis_fault", fault, 1'b1);
        check1("mis_no_req", imem_req, 1'b0);
        check1("mis_flushed", inst_valid, 1'b0);
        step(3);
        check1("mis_still_blocked", imem_req, 1'b0);
        check1("mis_sticky", fault, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        expect_inst(32'h0000_0300, 32'hA000_0300);
        expect_inst(32'h0000_0304, 32'hA000_0304);
        step(1);
        redirect_valid = 1'b0;
        check1("realign_fault", fault, 1'b0);
        check1("realign_req", imem_req, 1'b1);
        check32("realign_addr", imem_addr, 32'h0000_0300);
`else
        expect_inst(32'h0000_0100, 32'hA000_0100);
        expect_inst(32'h0000_0104, 32'hA000_0104);
        step(1);
        redirect_valid = 1'b0;
        check1("mis_fault", fault, 1'b0);
        check1("mis_flushed", inst_valid, 1'b0);
        check1("mis_req", imem_req, 1'b1);
        check32("mis_aligned_addr", imem_addr, 32'h0000_0100);
`endif
        inst_ready = 1'b1;
        wait_pops(2, 10, "mis_stream");

        // reset mid-wait, stray ack right after release
        inst_ready = 1'b1;
        hold_on    = 1'b1;
        hold_addr  = 32'h0000_0000;
        do_reset();
        step(3);
        check1("midwait_req", imem_req, 1'b1);
        check32("midwait_addr", imem_addr, 32'h0000_0000);
        rst_n = 1'b0;
        exp_q.delete();
        pops = 0;
        step(1);
        check1("midrst_req", imem_req, 1'b0);
        check1("midrst_valid", inst_valid, 1'b0);
        step(1);
        hold_on   = 1'b0;
        rst_n     = 1'b1;
        stray_ack = 1'b1;
        expect_inst(32'h0000_0000, 32'hA000_0000);
        expect_inst(32'h0000_0004, 32'hA000_0004);
        step(1);
        stray_ack = 1'b0;
        check1("relaunch_req", imem_req, 1'b1);
        check32("relaunch_addr", imem_addr, 32'h0000_0000);
        check1("stray_ignored", inst_valid, 1'b0);
        wait_pops(2, 10, "relaunch_stream");

        inst_ready = 1'b0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: imem_req  output  1  instruction-memory read request.
REQ-005 Port: imem_addr  output  32  byte address of requested word.
REQ-006 Port: imem_ack  input  1  read data valid; sampled only while imem_req=1.
REQ-007 Port: imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-008 Port: redirect_valid  input  1  branch/jump redirect strobe.
REQ-009 Port: redirect_pc  input  32  redirect target address.
REQ-010 Port: inst_valid  output  1  inst/inst_pc hold a valid instruction for the decoder.
REQ-011 Port: inst_ready  input  1  decoder accepts; transfer when inst_valid&&inst_ready.
REQ-012 Port: inst  output  32  instruction word to decoder (opcode in bits 31:26).
REQ-013 Port: inst_pc  output  32  address of inst.
REQ-014 Port: fault  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-015 The block SHALL hold a 32-bit PC and a two-state FSM: IDLE (no request outstanding), WAIT (one request outstanding); at most one request outstanding.
REQ-016 In IDLE with buffer count<2 and no redirect, the block SHALL assert imem_req with imem_addr=PC, advance PC by 4 (mod 2^32) and enter WAIT.
REQ-017 In WAIT, imem_req and imem_addr SHALL stay stable until imem_ack; ack in the same cycle as req is legal.
REQ-018 On imem_ack, the block SHALL push {request address, imem_rdata} into a 2-entry FIFO and return to IDLE, unless the request is squashed.
REQ-019 FIFO head SHALL drive inst/inst_pc; inst_valid = (count!=0); pop on inst_valid&&inst_ready; push+pop same cycle leaves count unchanged.
REQ-020 inst/inst_pc SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-021 redirect_valid SHALL flush the FIFO (inst_valid=0 next cycle), load PC=redirect_pc, and take priority over pop, push and new issue in that cycle.
REQ-022 Redirect while WAIT without ack SHALL set a squash flag; the pending ack SHALL be dropped, flag cleared, and the FSM return to IDLE.
REQ-023 Redirect in the same cycle as imem_ack SHALL drop that data; no squash flag is set.
REQ-024 Latency: redirect in cycle N -> imem_req with addr=redirect_pc in N+1 if no request outstanding; ack in cycle M -> inst_valid=1 in M+1.

Reset
REQ-025 While rst_n=0: PC=RESET_PC, FSM=IDLE, FIFO empty, squash=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0, fault=0.
REQ-026 Reset asserted mid-WAIT SHALL abandon the request; the late ack after release is ignored because imem_req=0.
REQ-027 First request SHALL issue in the first clock edge after rst_n rises, addr=RESET_PC.

Configuration
REQ-028 With FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 SHALL set fault (sticky), flush, and block issue until an aligned redirect or reset clears it.
REQ-029 Without FETCH_ALIGN_CHECK_EN: fault SHALL be tied 0 and redirect_pc[1:0] SHALL be forced to 2'b00.

Structure
REQ-030 Shared package cpu32_pkg SHALL hold word width, RESET_PC default, FSM state enum and the FIFO entry typedef {pc, inst}.
REQ-031 The 2-entry FIFO SHALL be a sub-module fetch_buffer (push, pop, flush, count, head); all other logic in fetch_unit.

Verification
REQ-032 Reset release, ack 1 cycle after each req, inst_ready=1 -> addrs 0x0,0x4,0x8 in order; inst_pc matches; no gaps beyond memory latency.
REQ-033 inst_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0, head stable; ready=1 -> words 0x0,0x4 then 0x8 fetched.
REQ-034 Redirect to 0x100 while WAIT on 0x8, ack 3 cycles later -> 0x8 data dropped, next req addr=0x100, first inst_pc=0x100.
REQ-035 Redirect to 0x200 same cycle as ack and pop -> FIFO empty next cycle, req addr=0x200 issued in N+1.
REQ-036 FETCH_ALIGN_CHECK_EN build, redirect 0x102 -> fault=1, no req; redirect 0x300 -> fault=0, req addr=0x300. Non-EN build: redirect 0x102 -> req addr=0x100.
REQ-037 rst_n low mid-WAIT, ack after release -> ack ignored, first req addr=RESET_PC.
